marker_ctrl: RTL and testbench

//  Sequences the red object-marker overlay on the VGA path. Takes raw per-frame object

---
 rtl/marker_ctrl_pkg.sv | 20 ++
 rtl/frame_event_counter.sv | 37 +++
 rtl/marker_ctrl.sv | 166 ++++++++++++++++
 tb/tb_marker_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/marker_ctrl_pkg.sv
// Shared definitions for the object-marker sequencer: state encodings, counter width
// and the saturating increment used by the frame event counters.
package marker_ctrl_pkg;

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Encodings are fixed: the overlay debug readout decodes these values directly.
  typedef enum logic [1:0] {
    StOff    = 2'd0,
    StSearch = 2'd1,
    StTrack  = 2'd2,
    StCoast  = 2'd3
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/frame_event_counter.sv
// 4-bit saturating frame event counter with synchronous clear and a terminal-match flag.
// hit reports that the increment requested this cycle reaches TERMINAL (or beyond).
module frame_event_counter
  import marker_ctrl_pkg::*;
#(
  parameter int unsigned TERMINAL = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic hit
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(TERMINAL);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;

  // Incremented value and terminal match; hit does not depend on clear.
  always_comb begin
    count_inc = sat_inc(count);
    hit       = inc && (count_inc >= TERM);
  end

  // Count register: clear has priority over increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count_inc;
    end
  end

endmodule

// File: rtl/marker_ctrl.sv
// Object-marker sequencer. Collects per-frame measurements into a shadow register and
// publishes them to the overlay only at frame boundaries; tracks lock state and drives
// a solid, blinking or absent marker.
module marker_ctrl
  import marker_ctrl_pkg::*;
#(
  parameter int unsigned DISP_WIDTH   = 11,
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned ACQ_FRAMES   = 3,
  parameter int unsigned LOST_FRAMES  = 8,
  parameter int unsigned BLINK_FRAMES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  frame_start,
  input  logic                  meas_valid,
  input  logic [DISP_WIDTH-1:0] x_meas,
  input  logic [DISP_WIDTH-1:0] y_meas,
  output logic [DISP_WIDTH-1:0] x_obj,
  output logic [DISP_WIDTH-1:0] y_obj,
  output logic                  marker_en,
  output logic                  locked,
  output logic [1:0]            state
);

  localparam logic [DISP_WIDTH-1:0] H_LIM = DISP_WIDTH'(H_ACTIVE);
  localparam logic [DISP_WIDTH-1:0] V_LIM = DISP_WIDTH'(V_ACTIVE);

  state_e                cur_state;
  logic                  blink_on;
  logic                  seen;
  logic [DISP_WIDTH-1:0] shadow_x;
  logic [DISP_WIDTH-1:0] shadow_y;

  logic in_range;
  logic closing;
  logic acq_inc, acq_clear, acq_hit;
  logic miss_inc, miss_clear, miss_hit;
  logic blink_inc, blink_clear, blink_hit;

  assign in_range = meas_valid && (x_meas < H_LIM) && (y_meas < V_LIM);
  // A frame closes only while enabled; frame_start during disable is meaningless.
  assign closing  = enable && frame_start;

  // Counter controls kept as separate assigns so no block both reads and feeds a hit flag.
  assign acq_inc     = closing && (cur_state == StSearch) && seen;
  assign acq_clear   = !enable || (closing && (cur_state == StSearch) && (!seen || acq_hit));
  assign miss_inc    = closing && !seen && ((cur_state == StTrack) || (cur_state == StCoast));
  assign miss_clear  = !enable || (closing && (cur_state == StCoast) && (seen || miss_hit));
  assign blink_inc   = closing && (cur_state == StCoast) && !seen && !miss_hit;
  assign blink_clear = !enable || (closing && (cur_state == StTrack)) || blink_hit;

  frame_event_counter #(
    .TERMINAL(ACQ_FRAMES)
  ) u_acq_cnt (
    .clk  (clk),
    .reset(reset),
    .clear(acq_clear),
    .inc  (acq_inc),
    .hit  (acq_hit)
  );

  frame_event_counter #(
    .TERMINAL(LOST_FRAMES)
  ) u_miss_cnt (
    .clk  (clk),
    .reset(reset),
    .clear(miss_clear),
    .inc  (miss_inc),
    .hit  (miss_hit)
  );

  frame_event_counter #(
    .TERMINAL(BLINK_FRAMES)
  ) u_blink_cnt (
    .clk  (clk),
    .reset(reset),
    .clear(blink_clear),
    .inc  (blink_inc),
    .hit  (blink_hit)
  );

  // Shadow capture: last in-range measurement wins; a measurement coincident with
  // frame_start belongs to the new frame, so seen restarts from it.
  always_ff @(posedge clk) begin
    if (reset) begin
      seen     <= 1'b0;
      shadow_x <= '0;
      shadow_y <= '0;
    end else if (!enable) begin
      seen <= 1'b0;
    end else begin
      if (in_range) begin
        shadow_x <= x_meas;
        shadow_y <= y_meas;
      end
      seen <= in_range || (seen && !frame_start);
    end
  end

  // Lock FSM with registered marker outputs; publishes shadow on entry to or stay in TRACK.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= StOff;
      x_obj     <= '0;
      y_obj     <= '0;
      marker_en <= 1'b0;
      blink_on  <= 1'b0;
    end else if (!enable) begin
      cur_state <= StOff;
      marker_en <= 1'b0;
      blink_on  <= 1'b0;
    end else begin
      case (cur_state)
        StOff: begin
          cur_state <= StSearch;
        end
        StSearch: begin
          if (closing && seen && acq_hit) begin
            cur_state <= StTrack;
            x_obj     <= shadow_x;
            y_obj     <= shadow_y;
            marker_en <= 1'b1;
          end
        end
        StTrack: begin
          if (closing) begin
            if (seen) begin
              x_obj <= shadow_x;
              y_obj <= shadow_y;
            end else begin
              cur_state <= StCoast;
              blink_on  <= 1'b1;
              marker_en <= 1'b1;
            end
          end
        end
        StCoast: begin
          if (closing) begin
            if (seen) begin
              cur_state <= StTrack;
              x_obj     <= shadow_x;
              y_obj     <= shadow_y;
              marker_en <= 1'b1;
            end else if (miss_hit) begin
              cur_state <= StSearch;
              marker_en <= 1'b0;
            end else if (blink_hit) begin
              blink_on  <= !blink_on;
              marker_en <= !blink_on;
            end
          end
        end
        default: begin
          cur_state <= StOff;
        end
      endcase
    end
  end

  assign state  = cur_state;
  assign locked = (cur_state == StTrack) || (cur_state == StCoast);

endmodule

// File: tb/tb_marker_ctrl.sv
// Self-checking bench for marker_ctrl: a hand-derived vector table, directed frame
// sequences for the multi-frame corners, and randomized traffic against a frame-level model.
module tb_marker_ctrl;

  localparam int unsigned W     = 11;
  localparam int          ACQ   = 3;
  localparam int          LOST  = 8;
  localparam int          BLINK = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         frame_start;
  logic         meas_valid;
  logic [W-1:0] x_meas;
  logic [W-1:0] y_meas;
  logic [W-1:0] x_obj;
  logic [W-1:0] y_obj;
  logic         marker_en;
  logic         locked;
  logic [1:0]   state;

  marker_ctrl #(
    .DISP_WIDTH  (W),
    .H_ACTIVE    (640),
    .V_ACTIVE    (480),
    .ACQ_FRAMES  (ACQ),
    .LOST_FRAMES (LOST),
    .BLINK_FRAMES(BLINK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .frame_start(frame_start),
    .meas_valid (meas_valid),
    .x_meas     (x_meas),
    .y_meas     (y_meas),
    .x_obj      (x_obj),
    .y_obj      (y_obj),
    .marker_en  (marker_en),
    .locked     (locked),
    .state      (state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: mode 0=OFF 1=SEARCH 2=TRACK 3=COAST; good = valid frames in a row while
  // searching, lost = missed frames in a row since leaving TRACK.
  int m_mode, m_seen, m_sx, m_sy, m_x, m_y, m_good, m_lost;

  typedef struct {
    int r, e, fs, mv, x, y;
    int st, ox, oy, men, lk;
  } vec_t;
  vec_t tbl[15];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_men();
    if (m_mode == 2) return 1;
    if (m_mode == 3) return (((m_lost - 1) / BLINK) % 2 == 0) ? 1 : 0;
    return 0;
  endfunction

  task automatic model_step(input int r, e, fs, mv, x, y);
    int inr;
    if (r != 0) begin
      m_mode = 0; m_seen = 0; m_sx = 0; m_sy = 0; m_x = 0; m_y = 0; m_good = 0; m_lost = 0;
    end else if (e == 0) begin
      m_mode = 0; m_seen = 0; m_good = 0; m_lost = 0;
    end else begin
      inr = (mv != 0 && x < 640 && y < 480) ? 1 : 0;
      if (m_mode == 0) begin
        m_mode = 1;
      end else if (fs != 0) begin
        if (m_seen != 0) begin
          if (m_mode == 1) begin
            m_good++;
            if (m_good >= ACQ) begin
              m_mode = 2; m_good = 0;
            end
          end else begin
            m_mode = 2; m_lost = 0;
          end
          if (m_mode == 2) begin
            m_x = m_sx; m_y = m_sy;
          end
        end else begin
          if (m_mode == 1) m_good = 0;
          else if (m_mode == 2) begin
            m_mode = 3; m_lost = 1;
          end else begin
            m_lost++;
            if (m_lost >= LOST) begin
              m_mode = 1; m_lost = 0; m_good = 0;
            end
          end
        end
      end
      m_seen = (fs != 0) ? inr : (m_seen | inr);
      if (inr != 0) begin
        m_sx = x; m_sy = y;
      end
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare 1 time unit later.
  task automatic cycle(input int r, e, fs, mv, x, y);
    reset       = r[0];
    enable      = e[0];
    frame_start = fs[0];
    meas_valid  = mv[0];
    x_meas      = W'(x);
    y_meas      = W'(y);
    @(posedge clk);
    model_step(r, e, fs, mv, x, y);
    #1;
    check("model.state", int'(state), m_mode);
    check("model.x_obj", int'(x_obj), m_x);
    check("model.y_obj", int'(y_obj), m_y);
    check("model.marker_en", int'(marker_en), model_men());
    check("model.locked", int'(locked), (m_mode >= 2) ? 1 : 0);
  endtask

  task automatic frame(input int mv, x, y);
    cycle(0, 1, 1, 0, 0, 0);
    cycle(0, 1, 0, mv, x, y);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
  endtask

  task automatic frame_co(input int x, y);
    cycle(0, 1, 1, 1, x, y);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
  endtask

  task automatic expect_out(input string name, input int st, ox, oy, men, lk);
    check({name, ".state"}, int'(state), st);
    check({name, ".x_obj"}, int'(x_obj), ox);
    check({name, ".y_obj"}, int'(y_obj), oy);
    check({name, ".marker_en"}, int'(marker_en), men);
    check({name, ".locked"}, int'(locked), lk);
  endtask

  initial begin
    int flen, fcnt, present, r, e, fs, mv;

    //          r  e  fs mv  x    y    st  ox   oy  men lk
    tbl[0]  = '{1, 0, 0, 0, 0,   0,   0,  0,   0,  0,  0};
    tbl[1]  = '{0, 1, 0, 0, 0,   0,   1,  0,   0,  0,  0};
    tbl[2]  = '{0, 1, 0, 1, 100, 50,  1,  0,   0,  0,  0};
    tbl[3]  = '{0, 1, 1, 0, 0,   0,   1,  0,   0,  0,  0};
    tbl[4]  = '{0, 1, 0, 1, 100, 50,  1,  0,   0,  0,  0};
    tbl[5]  = '{0, 1, 1, 0, 0,   0,   1,  0,   0,  0,  0};
    tbl[6]  = '{0, 1, 0, 1, 100, 50,  1,  0,   0,  0,  0};
    tbl[7]  = '{0, 1, 1, 0, 0,   0,   2,  100, 50, 1,  1};
    tbl[8]  = '{0, 1, 0, 0, 0,   0,   2,  100, 50, 1,  1};
    tbl[9]  = '{0, 1, 0, 1, 10,  10,  2,  100, 50, 1,  1};
    tbl[10] = '{0, 1, 0, 1, 20,  30,  2,  100, 50, 1,  1};
    tbl[11] = '{0, 1, 1, 0, 0,   0,   2,  20,  30, 1,  1};
    tbl[12] = '{0, 0, 0, 0, 0,   0,   0,  20,  30, 0,  0};
    tbl[13] = '{0, 0, 1, 1, 5,   5,   0,  20,  30, 0,  0};
    tbl[14] = '{1, 1, 0, 0, 0,   0,   0,  0,   0,  0,  0};

    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].r, tbl[i].e, tbl[i].fs, tbl[i].mv, tbl[i].x, tbl[i].y);
      expect_out($sformatf("tbl%0d", i), tbl[i].st, tbl[i].ox, tbl[i].oy, tbl[i].men,
                 tbl[i].lk);
    end

    // Acquire, coast two frames, recover with a new position.
    cycle(0, 1, 0, 0, 0, 0);
    frame(1, 200, 100);
    frame(1, 200, 100);
    frame(1, 200, 100);
    frame(0, 0, 0);
    expect_out("acq", 2, 200, 100, 1, 1);
    frame(0, 0, 0);
    frame(0, 0, 0);
    expect_out("coast2", 3, 200, 100, 1, 1);
    frame(1, 300, 200);
    frame(0, 0, 0);
    expect_out("recover", 2, 300, 200, 1, 1);

    // Blink on 4 frames, off thereafter, then lost after 8 misses with position held.
    for (int k = 1; k <= 7; k++) begin
      frame(0, 0, 0);
      expect_out($sformatf("blink%0d", k), 3, 300, 200, (k <= 4) ? 1 : 0, 1);
    end
    frame(0, 0, 0);
    expect_out("lost", 1, 300, 200, 0, 0);

    // Out-of-range measurements never count toward acquisition.
    frame(1, 700, 10);
    frame(1, 10, 480);
    frame(1, 640, 479);
    frame(0, 0, 0);
    expect_out("range", 1, 300, 200, 0, 0);

    // Measurements coincident with frame_start belong to the frame being opened.
    frame_co(60, 70);
    frame_co(61, 71);
    frame_co(62, 72);
    expect_out("co3", 1, 300, 200, 0, 0);
    frame_co(63, 73);
    expect_out("co4", 2, 62, 72, 1, 1);

    // Reset while coasting clears everything.
    frame(0, 0, 0);
    frame(0, 0, 0);
    expect_out("precoast", 3, 63, 73, 1, 1);
    cycle(1, 1, 1, 1, 5, 5);
    expect_out("rst_coast", 0, 0, 0, 0, 0);

    // Randomized frames of varying length with intermittent objects.
    flen = 4; fcnt = 0; present = 1;
    for (int c = 0; c < 6000; c++) begin
      fs = (fcnt == 0) ? 1 : 0;
      if (fs != 0) begin
        flen    = int'($urandom_range(3, 8));
        present = ($urandom_range(0, 9) < 7) ? 1 : 0;
      end
      fcnt = (fcnt + 1 >= flen) ? 0 : fcnt + 1;
      mv = (present != 0 && $urandom_range(0, 2) == 0) ? 1 : 0;
      r  = ($urandom_range(0, 1499) == 0) ? 1 : 0;
      e  = ($urandom_range(0, 399) == 0) ? 0 : 1;
      cycle(r, e, fs, mv, int'($urandom_range(0, 760)), int'($urandom_range(0, 560)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
